// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its store-merge helper.
// Size encodings match the requester-side access size field.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Illegal size code, or a half/word access not naturally aligned.
  function automatic logic size_addr_err(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: size_addr_err = 1'b0;
      SZ_HALF: size_addr_err = lo[0];
      SZ_WORD: size_addr_err = (lo != 2'b00);
      default: size_addr_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte/half lane insert of right-justified store data into an existing word.
// Zero latency, no flow control; also intended for the cache write path.
module store_merge
  import dmem_arb_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  output logic [31:0] merged_word
);

  always_comb begin
    merged_word = old_word;
    case (size)
      SZ_BYTE: merged_word[{addr, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: merged_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: merged_word = wdata;
      default: merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single-ported data memory; sub-word stores become read-modify-write.
// Loads/word stores take 3 cycles, sub-word stores 4, errors 2; the losing port simply stays pending.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_readdata
);

  state_t            state;
  logic              rr_ptr;
  logic              gnt;
  logic              cmd_we;
  logic [1:0]        cmd_size;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_err;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] merged;

  logic              sel;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;
  logic [ADDR_W-1:0] word_addr;

  // On a tie the round-robin pointer names the winner; otherwise the lone requester wins.
  always_comb begin
    if (a_req && b_req) sel = rr_ptr;
    else                sel = b_req ? PORT_B : PORT_A;
    sel_we    = sel ? b_we    : a_we;
    sel_size  = sel ? b_size  : a_size;
    sel_addr  = sel ? b_addr  : a_addr;
    sel_wdata = sel ? b_wdata : a_wdata;
    sel_err   = size_addr_err(sel_size, sel_addr[1:0]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= PORT_A;
      gnt       <= PORT_A;
      cmd_we    <= 1'b0;
      cmd_size  <= SZ_BYTE;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_err   <= 1'b0;
      merge_q   <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (a_req || b_req) begin
            gnt       <= sel;
            rr_ptr    <= ~sel;
            cmd_we    <= sel_we;
            cmd_size  <= sel_size;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            cmd_err   <= sel_err;
            if (sel_err)                           state <= ST_DONE;
            else if (sel_we && sel_size != SZ_WORD) state <= ST_RMW_RD;
            else                                   state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!cmd_we) begin
            if (gnt == PORT_A) a_rdata <= mem_readdata;
            else               b_rdata <= mem_readdata;
          end
          state <= ST_DONE;
        end
        ST_RMW_RD: begin
          merge_q <= mem_readdata;
          state   <= ST_RMW_WR;
        end
        ST_RMW_WR: state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  store_merge u_merge (
    .old_word    (merge_q),
    .wdata       (cmd_wdata),
    .size        (cmd_size),
    .addr        (cmd_addr[1:0]),
    .merged_word (merged)
  );

  assign word_addr = {cmd_addr[ADDR_W-1:2], 2'b00};
  assign mem_size  = SZ_WORD;

  always_comb begin
    mem_addr      = '0;
    mem_writedata = '0;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    a_ready       = 1'b0;
    a_err         = 1'b0;
    b_ready       = 1'b0;
    b_err         = 1'b0;
    case (state)
      ST_ACCESS: begin
        mem_addr      = word_addr;
        mem_re        = !cmd_we;
        mem_we        = cmd_we;
        mem_writedata = cmd_we ? cmd_wdata : '0;
      end
      ST_RMW_RD: begin
        mem_addr = word_addr;
        mem_re   = 1'b1;
      end
      ST_RMW_WR: begin
        mem_addr      = word_addr;
        mem_we        = 1'b1;
        mem_writedata = merged;
      end
      ST_DONE: begin
        a_ready = (gnt == PORT_A);
        b_ready = (gnt == PORT_B);
        a_err   = (gnt == PORT_A) && cmd_err;
        b_err   = (gnt == PORT_B) && cmd_err;
      end
      default: ;
    endcase
  end

endmodule
